sram_mem_ctrl: RTL
==================

Name: sram_mem_ctrl

Overview:
- Parametrised, registered controller for the board's asynchronous SRAM: CE/OE/WE/byte-lane enables, ADDR, and a shared bidirectional Data bus.
- Replaces the ad-hoc SRAM strobing inside the processor top level.
- Offers a single-request req/ready port to the CPU or other bus master. Read and write wait states and bus turnaround are configurable.
- Drives SRAM pins directly. All pin outputs are registered.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, data width; must be a multiple of 8
NB, DATA_W/8, number of byte lanes (derived, not overridable)
RD_WAIT, 2, cycles OE/CE held low before read data is sampled (>=1)
WR_WAIT, 2, cycles WE held low per write (>=1)
TURN, 1, idle cycles after a read before the next request is accepted (>=0)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
req  in  1  master request valid
we_req  in  1  1 = write, 0 = read
addr  in  ADDR_W  request address
wdata  in  DATA_W  write data
be  in  NB  write byte enables, active high
ready  out  1  controller can accept a request this cycle
rdata  out  DATA_W  read data, held until the next read completes
rvalid  out  1  one-cycle pulse: rdata is valid
wdone  out  1  one-cycle pulse: write complete
CE, OE, WE  out  1 each  SRAM strobes, active low
BE_N  out  NB  byte-lane enables, active low (bit0 = LB, bit1 = UB for 16-bit)
ADDR  out  ADDR_W  SRAM address
Data  inout  DATA_W  SRAM data bus

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - CE=OE=WE=1, BE_N all 1, ADDR=0.
  - Data high-Z.
  - rdata=0, rvalid=0, wdone=0.
  - FSM=IDLE, so ready=1 once released.
- FSM states: IDLE, RD, RD_TURN, WR_SETUP, WR_PULSE, WR_HOLD. ready=1 only in IDLE.
- Acceptance:
  - req&&ready at a rising edge (edge 0) latches we_req/addr/wdata/be internally.
  - Later changes on the inputs have no effect.
  - req while ready=0 is ignored, not queued.
- Read (cycle n = the cycle after edge n-1):
  - Cycles 1..RD_WAIT: state RD, with CE=0, OE=0, BE_N all 0, ADDR=latched addr.
  - Data is sampled at the edge ending cycle RD_WAIT.
  - Cycle RD_WAIT+1: rvalid=1 and rdata=sampled value. CE=OE=1. State is RD_TURN for TURN cycles, or IDLE if TURN=0.
  - ready returns in cycle RD_WAIT+1+TURN.
- Write:
  - Cycle 1, WR_SETUP: CE=0, WE=1, ADDR and Data driven, BE_N=~be.
  - Cycles 2..WR_WAIT+1, WR_PULSE: WE=0.
  - Cycle WR_WAIT+2, WR_HOLD: WE=1, Data/ADDR/CE still held, wdone=1.
  - Cycle WR_WAIT+3: IDLE, CE=1, Data high-Z, ready=1.
- be==0 on a write: identical timing including wdone, but WE is never asserted.
- Bus discipline:
  - Data is driven only in WR_SETUP/WR_PULSE/WR_HOLD.
  - OE=0 never coincides with Data driven.
  - ADDR and BE_N are stable whenever WE=0.
- Idle state: CE=OE=WE=1, BE_N all 1, ADDR holds its last value.
- rvalid and wdone are never both 1.
- Reset mid-transaction: the transaction is abandoned with no rvalid/wdone. Strobes deassert and Data releases asynchronously.

Test Plan:
- Defaults throughout unless stated; a behavioural SRAM model is on the bus.
- Reset: assert Reset=0 with clock running -> CE=OE=WE=1, BE_N=2'b11, Data=Z, rvalid=wdone=0. After release, ready=1.
- Full write: accept write addr=20'h00012, wdata=16'hBEEF, be=2'b11 -> WE low exactly cycles 2–3; Data=BEEF in cycles 1–4; wdone in cycle 4; ready in cycle 5; model holds BEEF.
- Readback: read addr=20'h00012 -> OE=CE=0 in cycles 1–2; rvalid with rdata=BEEF in cycle 3; ready in cycle 4; Data never driven by the controller.
- Byte write: write wdata=16'h0055, be=2'b01 to 20'h00012 -> BE_N=2'b10 during the write. A subsequent read returns 16'hBE55. A write with be=2'b00 leaves memory unchanged and still produces wdone in cycle 4.
- Busy/ignore: hold req=1 and change addr to 20'h00040 during the read of 0x12 -> ADDR stays 0x12. The request is taken only once ready=1, after which ADDR=0x40.
- Reset during write: pull Reset low in cycle 2 of a write -> WE=1 and Data=Z immediately, no wdone. Repeat with RD_WAIT=1, TURN=0: back-to-back reads are accepted every 2 cycles with rvalid each time.

Source files
------------

// File: rtl/sram_mem_ctrl_if.sv
// Master-side request/response bus of the SRAM controller: one request in flight, ready only when idle.
// rvalid/wdone are single-cycle completion pulses; there is no response backpressure.
interface sram_mem_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    localparam int NB = DATA_W / 8;

    logic              req;
    logic              we_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              wdone;

    modport master (
        output req, we_req, addr, wdata, be,
        input  ready, rdata, rvalid, wdone
    );

    modport slave (
        input  req, we_req, addr, wdata, be,
        output ready, rdata, rvalid, wdone
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Registered asynchronous-SRAM controller: read = RD_WAIT+1 cycles to rvalid, write = WR_WAIT+2 to wdone.
// Accepts one request only while idle (ready); requests seen while busy are dropped, never queued.
module sram_mem_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1,
    localparam int NB     = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_mem_ctrl_if.slave    bus,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic [NB-1:0]     BE_N,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);
    typedef enum logic [2:0] {
        IDLE, RD, RD_TURN, WR_SETUP, WR_PULSE, WR_HOLD
    } state_t;

    localparam int MAX_RW   = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int MAX_WAIT = (MAX_RW > TURN) ? MAX_RW : TURN;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                wdone_q, wdone_d;
    logic                ce_q, ce_d;
    logic                oe_q, oe_d;
    logic                wen_q, wen_d;
    logic [NB-1:0]       ben_q, ben_d;
    logic                drive_q, drive_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    be_d    = bus.be;
                    cnt_d   = '0;
                    state_d = bus.we_req ? WR_SETUP : RD;
                end
            end
            RD: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d  = Data;
                    rvalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = (TURN > 0) ? RD_TURN : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RD_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == WR_LAST) begin
                    wdone_d = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WR_HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state so every strobe leaves a flop in step with the FSM.
    always_comb begin
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        wen_d   = 1'b1;
        ben_d   = '1;
        drive_d = 1'b0;

        unique case (state_d)
            RD: begin
                ce_d  = 1'b0;
                oe_d  = 1'b0;
                ben_d = '0;
            end
            WR_SETUP, WR_HOLD: begin
                ce_d    = 1'b0;
                ben_d   = ~be_d;
                drive_d = 1'b1;
            end
            WR_PULSE: begin
                ce_d    = 1'b0;
                ben_d   = ~be_d;
                drive_d = 1'b1;
                wen_d   = ~|be_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            ce_q     <= 1'b1;
            oe_q     <= 1'b1;
            wen_q    <= 1'b1;
            ben_q    <= '1;
            drive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            ce_q     <= ce_d;
            oe_q     <= oe_d;
            wen_q    <= wen_d;
            ben_q    <= ben_d;
            drive_q  <= drive_d;
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wdone  = wdone_q;

    assign CE   = ce_q;
    assign OE   = oe_q;
    assign WE   = wen_q;
    assign BE_N = ben_q;
    assign ADDR = addr_q;
    assign Data = drive_q ? wdata_q : {DATA_W{1'bz}};
endmodule
